// File: rtl/sram_bist_ctrl.sv
// sram_bist_ctrl
//   BIST sequencer for a single-port synchronous SRAM. A run has two passes.
//   Phase A writes (addr ^ PATTERN) to every word and then reads each word back
//   and compares it. Phase B does the same with ~(addr ^ PATTERN).
//   Every read takes two cycles. The issue cycle asserts ReadEn. The compare
//   cycle holds the address and samples ReadData, which the SRAM registered at
//   the end of the issue cycle.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   start        begin a run (accepted only in IDLE or DONE)
//   Address      SRAM address (zero-extended word counter)
//   WriteData    SRAM write data
//   WriteEn      SRAM write enable
//   ReadEn       SRAM read enable (never asserted together with WriteEn)
//   ReadData     SRAM read data
//   busy         run in progress
//   done         run finished; held until the next start or reset
//   pass         while done=1: no mismatches were seen
//   fail_addr    address of the first mismatch (0 if there was none)
//   err_count    number of mismatching reads, saturating at 16'hFFFF
module sram_bist_ctrl #(
    parameter int                DEPTH   = 256,
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(32'hA5A5_A5A5)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [31:0]       Address,
    output logic [DATA_W-1:0] WriteData,
    output logic              WriteEn,
    output logic              ReadEn,
    input  logic [DATA_W-1:0] ReadData,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [31:0]       fail_addr,
    output logic [15:0]       err_count
);

    localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE, WA, RA_ISSUE, RA_CMP, WB, RB_ISSUE, RB_CMP, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [15:0]       err_q, err_d;
    logic [31:0]       fail_q, fail_d;
    logic              we_q, we_d, re_q, re_d;
    logic [31:0]       adr_q, adr_d;
    logic [DATA_W-1:0] wd_q, wd_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [DATA_W-1:0] pat_a(input logic [AW-1:0] a);
        return DATA_W'(a) ^ PATTERN;
    endfunction

    function automatic logic [DATA_W-1:0] pat_b(input logic [AW-1:0] a);
        return ~pat_a(a);
    endfunction

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = WA;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fail_d  = '0;
                end
            end
            WA: begin
                if (addr_q == LAST) begin
                    state_d = RA_ISSUE;
                    addr_d  = '0;
                end else begin
                    addr_d  = addr_q + AW'(1);
                end
            end
            RA_ISSUE: state_d = RA_CMP;
            RA_CMP: begin
                if (ReadData != pat_a(addr_q)) begin
                    err_d = sat_inc(err_q);
                    // err_q is cleared at start, so zero here means no earlier error
                    if (err_q == 16'd0) fail_d = 32'(addr_q);
                end
                if (addr_q == LAST) begin
                    state_d = WB;
                    addr_d  = '0;
                end else begin
                    state_d = RA_ISSUE;
                    addr_d  = addr_q + AW'(1);
                end
            end
            WB: begin
                if (addr_q == LAST) begin
                    state_d = RB_ISSUE;
                    addr_d  = '0;
                end else begin
                    addr_d  = addr_q + AW'(1);
                end
            end
            RB_ISSUE: state_d = RB_CMP;
            RB_CMP: begin
                if (ReadData != pat_b(addr_q)) begin
                    err_d = sat_inc(err_q);
                    if (err_q == 16'd0) fail_d = 32'(addr_q);
                end
                if (addr_q == LAST) begin
                    state_d = DONE;
                    addr_d  = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    // err_d already includes this final compare
                    pass_d  = (err_d == 16'd0);
                end else begin
                    state_d = RB_ISSUE;
                    addr_d  = addr_q + AW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // SRAM pins are decoded from the next state so they register with it
        we_d  = 1'b0;
        re_d  = 1'b0;
        adr_d = '0;
        wd_d  = '0;
        case (state_d)
            WA: begin
                we_d  = 1'b1;
                adr_d = 32'(addr_d);
                wd_d  = pat_a(addr_d);
            end
            WB: begin
                we_d  = 1'b1;
                adr_d = 32'(addr_d);
                wd_d  = pat_b(addr_d);
            end
            RA_ISSUE, RA_CMP, RB_ISSUE, RB_CMP: begin
                re_d  = 1'b1;
                adr_d = 32'(addr_d);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            adr_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            we_q    <= we_d;
            re_q    <= re_d;
            adr_q   <= adr_d;
            wd_q    <= wd_d;
        end
    end

    assign Address   = adr_q;
    assign WriteData = wd_q;
    assign WriteEn   = we_q;
    assign ReadEn    = re_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_addr = fail_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_sram_bist_ctrl.sv
module tb_sram_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, start4;

    // DEPTH=256 instance driving a behavioural SRAM
    logic [31:0] Address, WriteData, ReadData, fail_addr;
    logic        WriteEn, ReadEn, busy, done, pass;
    logic [15:0] err_count;

    // DEPTH=4 instance whose ReadData is stuck at zero
    logic [31:0] Address4, WriteData4, ReadData4, fail_addr4;
    logic        WriteEn4, ReadEn4, busy4, done4, pass4;
    logic [15:0] err_count4;

    int checks   = 0;
    int failures = 0;
    bit fault_mode = 1'b0;

    typedef struct {
        bit          pass;
        logic [15:0] err;
        logic [31:0] fa;
        int          busy_cycles;
    } exp_t;
    exp_t sbq[$];

    sram_bist_ctrl #(.DEPTH(256), .DATA_W(32), .PATTERN(32'hA5A5_A5A5)) dut (
        .clk(clk), .rst(rst), .start(start),
        .Address(Address), .WriteData(WriteData), .WriteEn(WriteEn), .ReadEn(ReadEn),
        .ReadData(ReadData), .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .err_count(err_count)
    );

    sram_bist_ctrl #(.DEPTH(4), .DATA_W(32), .PATTERN(32'hA5A5_A5A5)) dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .Address(Address4), .WriteData(WriteData4), .WriteEn(WriteEn4), .ReadEn(ReadEn4),
        .ReadData(ReadData4), .busy(busy4), .done(done4), .pass(pass4),
        .fail_addr(fail_addr4), .err_count(err_count4)
    );

    assign ReadData4 = 32'h0;

    // Synchronous SRAM: read data appears the cycle after ReadEn
    logic [31:0] mem [0:255];
    logic [31:0] rd_q;
    logic [7:0]  rd_addr_q;
    always @(posedge clk) begin
        if (WriteEn) mem[Address[7:0]] <= WriteData;
        if (ReadEn) begin
            rd_q      <= mem[Address[7:0]];
            rd_addr_q <= Address[7:0];
        end
    end
    // Optional stuck-at-1 on bit 3 of word 0x10
    assign ReadData = (fault_mode && rd_addr_q == 8'h10) ? (rd_q | 32'h8) : rd_q;

    task automatic pulse_start(input bit use4);
        @(negedge clk);
        if (use4) start4 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start4 = 1'b0;
    endtask

    // Called at the negedge right after start was accepted; observes until done.
    task automatic run_to_done(input bit use4, input int repulse_at,
                               output int busy_cnt, output bit timed_out, output bit overlap,
                               output logic [31:0] wd5a, output logic [31:0] wd5b);
        int n;
        int w5;
        busy_cnt = 0; timed_out = 1'b0; overlap = 1'b0;
        wd5a = 32'h0; wd5b = 32'h0; n = 0; w5 = 0;
        forever begin
            if (use4 ? busy4 : busy) busy_cnt++;
            if (use4) begin
                if (WriteEn4 && ReadEn4) overlap = 1'b1;
            end else begin
                if (WriteEn && ReadEn) overlap = 1'b1;
                if (WriteEn && Address == 32'd5) begin
                    if (w5 == 0) wd5a = WriteData;
                    else if (w5 == 1) wd5b = WriteData;
                    w5++;
                end
            end
            if (use4 ? done4 : done) break;
            if (n >= 20000) begin timed_out = 1'b1; break; end
            if (n == repulse_at) start = 1'b1;
            if (n == repulse_at + 1) start = 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start4 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (Address !== 32'h0) begin failures++; $display("FAIL reset_Address got=%h want=0", Address); end
        checks++; if (WriteData !== 32'h0) begin failures++; $display("FAIL reset_WriteData got=%h want=0", WriteData); end
        checks++; if (WriteEn !== 1'b0) begin failures++; $display("FAIL reset_WriteEn got=%b want=0", WriteEn); end
        checks++; if (ReadEn !== 1'b0) begin failures++; $display("FAIL reset_ReadEn got=%b want=0", ReadEn); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL reset_pass got=%b want=0", pass); end
        checks++; if (fail_addr !== 32'h0) begin failures++; $display("FAIL reset_fail_addr got=%h want=0", fail_addr); end
        checks++; if (err_count !== 16'h0) begin failures++; $display("FAIL reset_err_count got=%h want=0", err_count); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL idle_hold busy=%b done=%b want 0/0", busy, done); end
    endtask

    task automatic check_result(input string nm, input bit use4, input int bc, input bit to);
        // Pops one scoreboard entry and compares it with the finished run.
        exp_t e;
        if (sbq.size() == 0) begin
            checks++; failures++; $display("FAIL %s_scoreboard got=empty want=entry", nm);
            return;
        end
        e = sbq.pop_front();
        checks++; if (to) begin failures++; $display("FAIL %s_timeout got=no_done want=done", nm); end
        checks++; if (bc !== e.busy_cycles) begin failures++; $display("FAIL %s_busy_cycles got=%0d want=%0d", nm, bc, e.busy_cycles); end
        checks++; if ((use4 ? busy4 : busy) !== 1'b0) begin failures++; $display("FAIL %s_busy_at_done got=1 want=0", nm); end
        checks++; if ((use4 ? pass4 : pass) !== e.pass) begin failures++; $display("FAIL %s_pass got=%b want=%b", nm, use4 ? pass4 : pass, e.pass); end
        checks++; if ((use4 ? err_count4 : err_count) !== e.err) begin failures++; $display("FAIL %s_err_count got=%0d want=%0d", nm, use4 ? err_count4 : err_count, e.err); end
        checks++; if ((use4 ? fail_addr4 : fail_addr) !== e.fa) begin failures++; $display("FAIL %s_fail_addr got=%h want=%h", nm, use4 ? fail_addr4 : fail_addr, e.fa); end
    endtask

    task automatic test_fault_free();
        int bc; bit to, ov; logic [31:0] a5, b5;
        sbq.push_back('{pass: 1'b1, err: 16'd0, fa: 32'h0, busy_cycles: 1536});
        pulse_start(1'b0);
        run_to_done(1'b0, -1, bc, to, ov, a5, b5);
        check_result("fault_free", 1'b0, bc, to);
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL we_re_overlap got=1 want=0"); end
        checks++; if (a5 !== 32'hA5A5A5A0) begin failures++; $display("FAIL wa_addr5_data got=%h want=A5A5A5A0", a5); end
        checks++; if (b5 !== 32'h5A5A5A5F) begin failures++; $display("FAIL wb_addr5_data got=%h want=5A5A5A5F", b5); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL done_held got=%b want=1", done); end
        checks++; if ({WriteEn, ReadEn} !== 2'b00 || Address !== 32'h0 || WriteData !== 32'h0) begin
            failures++; $display("FAIL done_pins got=we%b re%b a%h d%h want=all 0", WriteEn, ReadEn, Address, WriteData);
        end
    endtask

    task automatic test_stuck_bit();
        int bc; bit to, ov; logic [31:0] a5, b5;
        fault_mode = 1'b1;
        sbq.push_back('{pass: 1'b0, err: 16'd1, fa: 32'h10, busy_cycles: 1536});
        pulse_start(1'b0);
        run_to_done(1'b0, -1, bc, to, ov, a5, b5);
        check_result("stuck_bit", 1'b0, bc, to);
        fault_mode = 1'b0;
    endtask

    task automatic test_depth4_zero();
        int bc; bit to, ov; logic [31:0] a5, b5;
        sbq.push_back('{pass: 1'b0, err: 16'd8, fa: 32'h0, busy_cycles: 24});
        pulse_start(1'b1);
        run_to_done(1'b1, -1, bc, to, ov, a5, b5);
        check_result("depth4_zero", 1'b1, bc, to);
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL d4_we_re_overlap got=1 want=0"); end
    endtask

    task automatic test_reset_midrun();
        int bc; bit to, ov; logic [31:0] a5, b5;
        pulse_start(1'b0);
        repeat (299) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrun_busy_before got=%b want=1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({busy, done, pass, WriteEn, ReadEn} !== 5'b0) begin
            failures++; $display("FAIL async_reset_ctrl got=%b want=00000", {busy, done, pass, WriteEn, ReadEn});
        end
        checks++; if (Address !== 32'h0 || WriteData !== 32'h0 || fail_addr !== 32'h0 || err_count !== 16'h0) begin
            failures++; $display("FAIL async_reset_data got=a%h d%h f%h e%h want=0", Address, WriteData, fail_addr, err_count);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || WriteEn !== 1'b0) begin failures++; $display("FAIL post_reset_idle busy=%b we=%b want 0/0", busy, WriteEn); end
        sbq.push_back('{pass: 1'b1, err: 16'd0, fa: 32'h0, busy_cycles: 1536});
        pulse_start(1'b0);
        run_to_done(1'b0, -1, bc, to, ov, a5, b5);
        check_result("after_reset", 1'b0, bc, to);
    endtask

    task automatic test_back_to_back();
        int bc; bit to, ov; logic [31:0] a5, b5;
        fault_mode = 1'b1;
        sbq.push_back('{pass: 1'b0, err: 16'd1, fa: 32'h10, busy_cycles: 1536});
        pulse_start(1'b0);
        run_to_done(1'b0, 100, bc, to, ov, a5, b5);
        check_result("restart_ignored", 1'b0, bc, to);
        fault_mode = 1'b0;
        pulse_start(1'b0);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL restart_done got=%b want=0", done); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL restart_pass got=%b want=0", pass); end
        checks++; if (err_count !== 16'h0) begin failures++; $display("FAIL restart_err_count got=%0d want=0", err_count); end
        checks++; if (fail_addr !== 32'h0) begin failures++; $display("FAIL restart_fail_addr got=%h want=0", fail_addr); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL restart_busy got=%b want=1", busy); end
        sbq.push_back('{pass: 1'b1, err: 16'd0, fa: 32'h0, busy_cycles: 1536});
        run_to_done(1'b0, -1, bc, to, ov, a5, b5);
        check_result("second_run", 1'b0, bc, to);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start4 = 1'b0;
        test_reset();
        test_fault_free();
        test_stuck_bit();
        test_depth4_zero();
        test_reset_midrun();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
